sort4_seq: RTL and testbench

Sequenced 4-entry sorter for the EDA7 sort experiments. Loads a batch of four W-bit samples over a valid/ready handshake, then sorts them in place using a single shared compare-swap unit driven by a fixed 6-step schedule (odd/even bubble order). Presents the sorted batch on ra..rd with a done/ack handshake. Sits between the sample source and downstream display/check logic, in place of a fully parallel sorting network.

---
 rtl/sort4_seq.sv | 133 +++++++++++++
 tb/tb_sort4_seq.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/sort4_seq.sv
// Sequenced 4-entry sorter: loads four samples over valid/ready, then sorts them in
// place with one shared compare-swap unit on a fixed 6-step bubble schedule.
`timescale 1ns/1ps
module sort4_seq #(
   parameter int W       = 8,
   parameter bit DESCEND = 1'b0
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [W-1:0] a,
   input  logic         a_valid,
   output logic         a_ready,
   output logic [W-1:0] ra,
   output logic [W-1:0] rb,
   output logic [W-1:0] rc,
   output logic [W-1:0] rd,
   output logic         done,
   input  logic         out_ack,
   output logic         busy,
   output logic [2:0]   swap_cnt
);

   typedef enum logic [1:0] {LOAD, SORT, DONE} state_t;

   state_t       state_q;
   logic [1:0]   idx_q;
   logic [2:0]   step_q;
   logic [W-1:0] slot_q [4];
   logic [2:0]   swap_cnt_q;
   logic         done_q;
   logic         busy_q;
   logic         a_ready_q;

   logic [1:0]   lidx_d;
   logic [1:0]   ridx_d;
   logic [W-1:0] left_d;
   logic [W-1:0] right_d;
   logic         swap_d;

   // Strict unsigned compare, so equal values are never swapped.
   function automatic logic out_of_order(input logic [W-1:0] l, input logic [W-1:0] r);
      return DESCEND ? (l < r) : (l > r);
   endfunction

   always_comb begin
      lidx_d = 2'd0;
      ridx_d = 2'd1;
      case (step_q)
         3'd1, 3'd4: begin
            lidx_d = 2'd1;
            ridx_d = 2'd2;
         end
         3'd2: begin
            lidx_d = 2'd2;
            ridx_d = 2'd3;
         end
         default: begin
            lidx_d = 2'd0;
            ridx_d = 2'd1;
         end
      endcase
      left_d  = slot_q[lidx_d];
      right_d = slot_q[ridx_d];
      swap_d  = out_of_order(left_d, right_d);
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q    <= LOAD;
         idx_q      <= 2'd0;
         step_q     <= 3'd0;
         swap_cnt_q <= 3'd0;
         done_q     <= 1'b0;
         busy_q     <= 1'b0;
         a_ready_q  <= 1'b1;
         for (int i = 0; i < 4; i++) slot_q[i] <= '0;
      end else begin
         case (state_q)
            LOAD: begin
               if (a_valid) begin
                  slot_q[idx_q] <= a;
                  idx_q         <= idx_q + 2'd1;
                  if (idx_q == 2'd3) begin
                     state_q   <= SORT;
                     step_q    <= 3'd0;
                     a_ready_q <= 1'b0;
                     busy_q    <= 1'b1;
                  end
               end
            end
            SORT: begin
               if (swap_d) begin
                  slot_q[lidx_d] <= right_d;
                  slot_q[ridx_d] <= left_d;
                  swap_cnt_q     <= swap_cnt_q + 3'd1;
               end
               step_q <= step_q + 3'd1;
               if (step_q == 3'd5) begin
                  state_q <= DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end
            end
            DONE: begin
               // Slot contents are kept; the next batch simply overwrites them.
               if (out_ack) begin
                  state_q    <= LOAD;
                  done_q     <= 1'b0;
                  swap_cnt_q <= 3'd0;
                  idx_q      <= 2'd0;
                  a_ready_q  <= 1'b1;
               end
            end
            default: begin
               state_q   <= LOAD;
               a_ready_q <= 1'b1;
               busy_q    <= 1'b0;
               done_q    <= 1'b0;
            end
         endcase
      end
   end

   assign a_ready  = a_ready_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign swap_cnt = swap_cnt_q;
   assign ra       = slot_q[0];
   assign rb       = slot_q[1];
   assign rc       = slot_q[2];
   assign rd       = slot_q[3];

endmodule

// File: tb/tb_sort4_seq.sv
// Directed bench for sort4_seq: ascending and descending instances share one stimulus.
`timescale 1ns/1ps
module tb_sort4_seq;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] a;
   logic       a_valid;
   logic       out_ack;

   logic       a_ready_a, done_a, busy_a;
   logic [7:0] ra_a, rb_a, rc_a, rd_a;
   logic [2:0] swap_a;
   logic       a_ready_d, done_d, busy_d;
   logic [7:0] ra_d, rb_d, rc_d, rd_d;
   logic [2:0] swap_d;

   logic [31:0] res_a, res_d;
   assign res_a = {ra_a, rb_a, rc_a, rd_a};
   assign res_d = {ra_d, rb_d, rc_d, rd_d};

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   sort4_seq #(.W(8), .DESCEND(1'b0)) u_asc (
      .clk(clk), .reset(reset), .a(a), .a_valid(a_valid), .a_ready(a_ready_a),
      .ra(ra_a), .rb(rb_a), .rc(rc_a), .rd(rd_a),
      .done(done_a), .out_ack(out_ack), .busy(busy_a), .swap_cnt(swap_a)
   );

   sort4_seq #(.W(8), .DESCEND(1'b1)) u_dsc (
      .clk(clk), .reset(reset), .a(a), .a_valid(a_valid), .a_ready(a_ready_d),
      .ra(ra_d), .rb(rb_d), .rc(rc_d), .rd(rd_d),
      .done(done_d), .out_ack(out_ack), .busy(busy_d), .swap_cnt(swap_d)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] ref_sort(input logic [31:0] w, input bit desc);
      logic [7:0] v [4];
      logic [7:0] t;
      for (int i = 0; i < 4; i++) v[i] = w[31-8*i -: 8];
      for (int i = 0; i < 4; i++)
         for (int j = i + 1; j < 4; j++)
            if (desc ? (v[j] > v[i]) : (v[j] < v[i])) begin
               t = v[i]; v[i] = v[j]; v[j] = t;
            end
      return {v[0], v[1], v[2], v[3]};
   endfunction

   function automatic logic [31:0] ref_inv(input logic [31:0] w, input bit desc);
      logic [7:0] v [4];
      logic [31:0] n;
      n = 0;
      for (int i = 0; i < 4; i++) v[i] = w[31-8*i -: 8];
      for (int i = 0; i < 4; i++)
         for (int j = i + 1; j < 4; j++)
            if (desc ? (v[i] < v[j]) : (v[i] > v[j])) n++;
      return n;
   endfunction

   task automatic load4(input logic [31:0] w);
      for (int i = 0; i < 4; i++) begin
         a       = w[31-8*i -: 8];
         a_valid = 1'b1;
         tick();
      end
      a_valid = 1'b0;
   endtask

   task automatic wait_done(output int cyc, output int bcnt);
      cyc  = 0;
      bcnt = 0;
      while (done_a !== 1'b1 && cyc < 20) begin
         if (busy_a === 1'b1) bcnt++;
         tick();
         cyc++;
      end
   endtask

   task automatic check_batch(input string tag, input logic [31:0] w,
                              input logic [31:0] ea, input logic [31:0] sa,
                              input logic [31:0] ed, input logic [31:0] sd);
      int cyc, bc;
      load4(w);
      wait_done(cyc, bc);
      chk({tag, "_lat"}, cyc, 6);
      chk({tag, "_busy"}, bc, 6);
      chk({tag, "_done_d"}, 32'(done_d), 1);
      chk({tag, "_asc"}, res_a, ea);
      chk({tag, "_asc_swaps"}, 32'(swap_a), sa);
      chk({tag, "_dsc"}, res_d, ed);
      chk({tag, "_dsc_swaps"}, 32'(swap_d), sd);
      out_ack = 1'b1;
      tick();
      out_ack = 1'b0;
      chk({tag, "_ack_done"}, 32'(done_a), 0);
      chk({tag, "_ack_ready"}, 32'(a_ready_a), 1);
   endtask

   initial begin
      int cyc, bc;
      logic [31:0] w;

      reset = 1'b0; a = '0; a_valid = 1'b0; out_ack = 1'b0;
      tick();
      tick();
      reset = 1'b1;
      chk("rst_regs_a", res_a, 0);
      chk("rst_regs_d", res_d, 0);
      chk("rst_done", 32'({done_a, done_d}), 0);
      chk("rst_busy", 32'({busy_a, busy_d}), 0);
      chk("rst_swaps", 32'({swap_a, swap_d}), 0);
      chk("rst_ready", 32'({a_ready_a, a_ready_d}), 32'h3);

      check_batch("rev", 32'h04030201, 32'h01020304, 6, 32'h04030201, 0);
      chk("rev_keep_regs", res_a, 32'h01020304);
      chk("rev_swap_clr", 32'(swap_a), 0);
      check_batch("sorted", 32'h01020304, 32'h01020304, 0, 32'h04030201, 6);
      check_batch("equal", 32'h05050505, 32'h05050505, 0, 32'h05050505, 0);
      check_batch("mix", {8'd9, 8'd200, 8'd9, 8'd0},
                  {8'd0, 8'd9, 8'd9, 8'd200}, 4, {8'd200, 8'd9, 8'd9, 8'd0}, 1);

      // Gapped loads, out_ack during LOAD, a_valid left high through SORT/DONE.
      a = 8'd7;  a_valid = 1'b1; tick();
      a = 8'd99; a_valid = 1'b0; out_ack = 1'b1; tick();
      out_ack = 1'b0;
      a = 8'd3;  a_valid = 1'b1; tick();
      a = 8'd98; a_valid = 1'b0; tick(); tick();
      chk("gap_no_early_busy", 32'(busy_a), 0);
      chk("gap_still_ready", 32'(a_ready_a), 1);
      chk("gap_partial", {ra_a, rb_a}, 32'h0703);
      a = 8'd8;  a_valid = 1'b1; tick();
      a = 8'd1;  tick();
      a = 8'd77;
      chk("gap_ready_low", 32'(a_ready_a), 0);
      wait_done(cyc, bc);
      chk("gap_lat", cyc, 6);
      chk("gap_asc", res_a, 32'h01030708);
      chk("gap_asc_swaps", 32'(swap_a), 4);
      chk("gap_dsc", res_d, 32'h08070301);
      chk("gap_dsc_swaps", 32'(swap_d), 2);
      tick(); tick(); tick();
      chk("gap_done_held", 32'(done_a), 1);
      chk("gap_regs_stable", res_a, 32'h01030708);
      a_valid = 1'b0; out_ack = 1'b1; tick();
      out_ack = 1'b0;
      chk("gap_ack_done", 32'(done_a), 0);
      chk("gap_regs_kept", res_a, 32'h01030708);

      // out_ack held high from the start: done lasts exactly one cycle.
      out_ack = 1'b1;
      load4(32'h02010403);
      wait_done(cyc, bc);
      chk("hold_lat", cyc, 6);
      chk("hold_asc", res_a, 32'h01020304);
      chk("hold_asc_swaps", 32'(swap_a), 2);
      chk("hold_dsc_swaps", 32'(swap_d), 4);
      tick();
      chk("hold_done_1cyc", 32'(done_a), 0);
      chk("hold_ready", 32'(a_ready_a), 1);
      out_ack = 1'b0;

      // Reset while step 3 of SORT would execute.
      load4({8'd10, 8'd30, 8'd20, 8'd0});
      tick(); tick(); tick();
      chk("mid_swaps_pre", 32'(swap_a), 2);
      reset = 1'b0; tick();
      reset = 1'b1;
      chk("mid_rst_regs", res_a, 0);
      chk("mid_rst_swaps", 32'(swap_a), 0);
      chk("mid_rst_busy", 32'(busy_a), 0);
      chk("mid_rst_ready", 32'(a_ready_a), 1);
      tick();
      chk("mid_rst_idle", 32'({busy_a, done_a}), 0);
      check_batch("post_rst", {8'd10, 8'd30, 8'd20, 8'd0},
                  {8'd0, 8'd10, 8'd20, 8'd30}, 4, {8'd30, 8'd20, 8'd10, 8'd0}, 2);

      for (int k = 0; k < 50; k++) begin
         for (int i = 0; i < 4; i++) w[31-8*i -: 8] = 8'({$random} % 256);
         check_batch($sformatf("rnd%0d", k), w, ref_sort(w, 1'b0), ref_inv(w, 1'b0),
                     ref_sort(w, 1'b1), ref_inv(w, 1'b1));
         chk($sformatf("rnd%0d_order", k),
             32'((ra_d >= rb_d) && (rb_d >= rc_d) && (rc_d >= rd_d)), 1);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
